// File: rtl/alloc_pkg.sv
// Shared constants and sizing helper for the valid-entry allocation controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alloc_pkg;

    localparam int NUM_ENTRY_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int NUM_REQ_DEF    = 2;

    // Bits needed to index n items (0..n-1); never less than one bit so a
    // single-requester build still has a legal pointer register.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr (wrapping) wins.
// Latency: purely combinational, grant in the same cycle as req.
// Backpressure: none; caller gates req to suppress grants.
//
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - requester index with highest priority this cycle (< N)
//   gnt    - one-hot grant, all zero when req is zero
//   winner - binary index of the granted requester (0 when no grant)
module rr_arbiter
    import alloc_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int PW = cnt_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] winner
);

    always_comb begin
        int   idx;
        logic found;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            // Walk the requesters starting at ptr, wrapping past N-1.
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx -= N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/valid_entry_alloc_ctrl.sv
// Valid-bit slot allocator: hands lowest free entry to a round-robin winner, retires on release.
// Latency: grant/alloc_addr/lookup_valid combinational; state, count and error flags update next edge.
// Backpressure: no grant while full (registered) or flushing; requesters simply hold req.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   req / gnt        - per-requester level request, one-hot same-cycle grant
//   alloc_addr       - entry owned by the granted requester from the next cycle
//   free_en/addr     - release strobe and index (bad index or free entry raises an error pulse)
//   flush            - clears every entry next cycle; blocks grants and releases this cycle
//   lookup_addr/valid- combinational read of the registered valid array
//   free_count, full, empty, err_double_free, err_bad_addr - registered status
module valid_entry_alloc_ctrl
    import alloc_pkg::*;
#(
    parameter int NUM_ENTRY  = NUM_ENTRY_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  free_en,
    input  logic [ADDR_WIDTH-1:0] free_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  lookup_valid,
    output logic [ADDR_WIDTH:0]   free_count,
    output logic                  full,
    output logic                  empty,
    output logic                  err_double_free,
    output logic                  err_bad_addr
);

    localparam int PW = cnt_width(NUM_REQ);
    localparam int CW = ADDR_WIDTH + 1;
    // Address space can exceed NUM_ENTRY; the widened copy keeps indexing
    // in range and reads zero for out-of-range slots.
    localparam int VW = 1 << ADDR_WIDTH;

    localparam logic [CW-1:0] ENTRY_CNT = CW'(NUM_ENTRY);
    localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);

    logic [NUM_ENTRY-1:0] valid;
    logic [VW-1:0]        valid_ext;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        winner;
    logic [NUM_REQ-1:0]   arb_req;
    logic                 grant;
    logic                 free_in_range;
    logic                 free_legal;
    logic                 free_bad;
    logic                 free_dbl;
    logic [NUM_ENTRY-1:0] set_mask;
    logic [NUM_ENTRY-1:0] clr_mask;
    logic [CW-1:0]        cnt_next;

    assign valid_ext = VW'(valid);

    // full is the registered flag, so an entry released while full only
    // becomes grantable on the following cycle.
    assign arb_req = (rst || full || flush) ? '0 : req;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req    (arb_req),
        .ptr    (ptr),
        .gnt    (gnt),
        .winner (winner)
    );

    assign grant = |gnt;

    // Lowest-index free slot: scan downward so the last hit is the lowest.
    always_comb begin
        alloc_addr = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_addr = ADDR_WIDTH'(i);
            end
        end
    end

    assign lookup_valid = ({1'b0, lookup_addr} < ENTRY_CNT) && valid_ext[lookup_addr];

    // Release classification uses pre-edge state: the entry being granted
    // this cycle is still free, so releasing it counts as a double free.
    assign free_in_range = ({1'b0, free_addr} < ENTRY_CNT);
    assign free_bad      = free_en && !flush && !free_in_range;
    assign free_dbl      = free_en && !flush && free_in_range && !valid_ext[free_addr];
    assign free_legal    = free_en && !flush && free_in_range && valid_ext[free_addr];

    assign set_mask = grant      ? (NUM_ENTRY'(1) << alloc_addr) : '0;
    assign clr_mask = free_legal ? (NUM_ENTRY'(1) << free_addr)  : '0;
    assign cnt_next = free_count - CW'(grant) + CW'(free_legal);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid           <= '0;
            ptr             <= '0;
            free_count      <= ENTRY_CNT;
            full            <= 1'b0;
            empty           <= 1'b1;
            err_double_free <= 1'b0;
            err_bad_addr    <= 1'b0;
        end else if (flush) begin
            valid           <= '0;
            free_count      <= ENTRY_CNT;
            full            <= 1'b0;
            empty           <= 1'b1;
            err_double_free <= 1'b0;
            err_bad_addr    <= 1'b0;
        end else begin
            valid           <= (valid | set_mask) & ~clr_mask;
            free_count      <= cnt_next;
            full            <= (cnt_next == '0);
            empty           <= (cnt_next == ENTRY_CNT);
            err_double_free <= free_dbl;
            err_bad_addr    <= free_bad;
            if (grant) begin
                ptr <= (winner == LAST_REQ) ? '0 : winner + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_valid_entry_alloc_ctrl.sv
module tb_valid_entry_alloc_ctrl;

    localparam int NE = 16;
    localparam int AW = 5;   // wider than needed so out-of-range releases are expressible
    localparam int NR = 2;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [AW-1:0] alloc_addr;
    logic          free_en;
    logic [AW-1:0] free_addr;
    logic          flush;
    logic [AW-1:0] lookup_addr;
    logic          lookup_valid;
    logic [AW:0]   free_count;
    logic          full;
    logic          empty;
    logic          err_double_free;
    logic          err_bad_addr;

    valid_entry_alloc_ctrl #(
        .NUM_ENTRY  (NE),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .gnt             (gnt),
        .alloc_addr      (alloc_addr),
        .free_en         (free_en),
        .free_addr       (free_addr),
        .flush           (flush),
        .lookup_addr     (lookup_addr),
        .lookup_valid    (lookup_valid),
        .free_count      (free_count),
        .full            (full),
        .empty           (empty),
        .err_double_free (err_double_free),
        .err_bad_addr    (err_bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: set of occupied slots ----------------
    bit mv [NE];
    int mptr;
    bit m_dbl;
    bit m_bad;

    function automatic int m_free_cnt();
        int c;
        c = NE;
        for (int i = 0; i < NE; i++) c -= int'(mv[i]);
        return c;
    endfunction

    function automatic int m_lowfree();
        for (int i = 0; i < NE; i++) if (!mv[i]) return i;
        return 0;
    endfunction

    // Requester that should win this cycle, -1 if nobody.
    function automatic int m_winner(input int r, input int q, input int fl);
        int k;
        if (r != 0 || fl != 0 || q == 0 || m_free_cnt() == 0) return -1;
        for (int i = 0; i < NR; i++) begin
            k = (mptr + i) % NR;
            if (((q >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    function automatic void m_update(input int r, input int fe, input int fa, input int fl, input int w);
        int a;
        if (r != 0) begin
            for (int i = 0; i < NE; i++) mv[i] = 0;
            mptr = 0; m_dbl = 0; m_bad = 0;
        end else if (fl != 0) begin
            for (int i = 0; i < NE; i++) mv[i] = 0;
            m_dbl = 0; m_bad = 0;
        end else begin
            m_bad = (fe != 0) && (fa >= NE);
            m_dbl = (fe != 0) && (fa < NE) && !mv[fa];
            a = m_lowfree();
            if (w >= 0) begin
                mv[a] = 1;
                mptr  = (w + 1) % NR;
            end
            if ((fe != 0) && (fa < NE) && !m_dbl) mv[fa] = 0;
        end
    endfunction

    int act_gnt, act_addr, act_lk;

    // One clock: drive, check combinational outputs, clock, check registered outputs.
    task automatic step(input int r, input int q, input int fe, input int fa, input int fl, input int la);
        int w;
        rst         = (r != 0);
        req         = q[NR-1:0];
        free_en     = (fe != 0);
        free_addr   = fa[AW-1:0];
        flush       = (fl != 0);
        lookup_addr = la[AW-1:0];
        #1;
        w        = m_winner(r, q, fl);
        act_gnt  = int'(gnt);
        act_addr = int'(alloc_addr);
        act_lk   = int'(lookup_valid);
        chk("m_gnt", act_gnt, (w < 0) ? 0 : (1 << w));
        if (w >= 0) chk("m_alloc_addr", act_addr, m_lowfree());
        chk("m_lookup_valid", act_lk, (la < NE) ? int'(mv[la]) : 0);
        @(posedge clk);
        m_update(r, fe, fa, fl, w);
        #1;
        chk("m_free_count", int'(free_count), m_free_cnt());
        chk("m_full", int'(full), int'(m_free_cnt() == 0));
        chk("m_empty", int'(empty), int'(m_free_cnt() == NE));
        chk("m_err_double_free", int'(err_double_free), int'(m_dbl));
        chk("m_err_bad_addr", int'(err_bad_addr), int'(m_bad));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int rst, req, fe, fa, fl, la;          // inputs
        int e_gnt, e_addr, e_lk;               // comb expectations (-1 = don't check)
        int e_cnt, e_full, e_empty, e_dbl, e_bad; // after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int r, q, fe, fa, fl, la, eg, ea, el, ec, ef, ee, ed, eb);
        vec_t v;
        v.rst = r; v.req = q; v.fe = fe; v.fa = fa; v.fl = fl; v.la = la;
        v.e_gnt = eg; v.e_addr = ea; v.e_lk = el;
        v.e_cnt = ec; v.e_full = ef; v.e_empty = ee; v.e_dbl = ed; v.e_bad = eb;
        vecs.push_back(v);
    endfunction

    initial begin
        // Fill to full with requester 0, then no grant when full.
        for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 0, 0, 1, i, -1, 15 - i, int'(i == 15), 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0, -1, -1,  0, 1, 0, 0, 0);
        // Release 5 while full: grantable again next cycle, then full again.
        add(0, 0, 1, 5, 0, 0,  0, -1, -1,  1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  1,  5, -1,  0, 1, 0, 0, 0);
        // Flush from full with req high.
        add(0, 1, 0, 0, 1, 0,  0, -1, -1, 16, 0, 1, 0, 0);
        // Double free of 9, then bad address 17; each error lasts one cycle.
        add(0, 0, 1, 9, 0, 9,  0, -1,  0, 16, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,  0, -1, -1, 16, 0, 1, 0, 0);
        add(0, 0, 1, 17, 0, 0, 0, -1, -1, 16, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0,  0, -1, -1, 16, 0, 1, 0, 0);
        // Reset, then two requesters alternate from pointer 0.
        add(1, 3, 0, 0, 0, 0,  0, -1, -1, 16, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 3, 0, 0, 0, 0, (i % 2 != 0) ? 2 : 1, i, -1, 15 - i, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 1, 4 + i, -1, 11 - i, 0, 0, 0, 0);
        // Free 3, then grant 3 while releasing 7 in the same cycle.
        add(0, 0, 1, 3, 0, 0,  0, -1, -1,  9, 0, 0, 0, 0);
        add(0, 1, 1, 7, 0, 0,  1,  3, -1,  9, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 3,  0, -1,  1,  9, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 7,  0, -1,  0,  9, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  1,  7, -1,  8, 0, 0, 0, 0);
        // Flush with 8 allocated and req high.
        add(0, 1, 0, 0, 1, 0,  0, -1, -1, 16, 0, 1, 0, 0);
        // Release of the very entry being granted: allocation wins, double free flagged.
        add(0, 1, 1, 0, 0, 0,  1,  0, -1, 15, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,  0, -1,  1, 15, 0, 0, 0, 0);

        // ---- reset ----
        rst = 1'b1; req = '0; free_en = 1'b0; free_addr = '0; flush = 1'b0; lookup_addr = '0;
        for (int i = 0; i < NE; i++) mv[i] = 0;
        mptr = 0; m_dbl = 0; m_bad = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_free_count", int'(free_count), 16);
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_err_double_free", int'(err_double_free), 0);
        chk("rst_err_bad_addr", int'(err_bad_addr), 0);

        // ---- table ----
        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].req, vecs[n].fe, vecs[n].fa, vecs[n].fl, vecs[n].la);
            chk($sformatf("t%0d_gnt", n), act_gnt, vecs[n].e_gnt);
            if (vecs[n].e_addr >= 0) chk($sformatf("t%0d_alloc_addr", n), act_addr, vecs[n].e_addr);
            if (vecs[n].e_lk >= 0) chk($sformatf("t%0d_lookup_valid", n), act_lk, vecs[n].e_lk);
            chk($sformatf("t%0d_free_count", n), int'(free_count), vecs[n].e_cnt);
            chk($sformatf("t%0d_full", n), int'(full), vecs[n].e_full);
            chk($sformatf("t%0d_empty", n), int'(empty), vecs[n].e_empty);
            chk($sformatf("t%0d_err_double_free", n), int'(err_double_free), vecs[n].e_dbl);
            chk($sformatf("t%0d_err_bad_addr", n), int'(err_bad_addr), vecs[n].e_bad);
        end

        // ---- rst in the middle of a grant stream ----
        for (int i = 0; i < 3; i++) step(0, 3, 0, 0, 0, 0);
        step(1, 3, 1, 2, 1, 0);
        chk("midrst_free_count", int'(free_count), 16);
        chk("midrst_full", int'(full), 0);
        chk("midrst_empty", int'(empty), 1);
        chk("midrst_err_double_free", int'(err_double_free), 0);
        for (int a = 0; a < 20; a++) begin
            step(0, 0, 0, 0, 0, a);
            chk($sformatf("midrst_lookup%0d", a), act_lk, 0);
            chk("midrst_idle_gnt", act_gnt, 0);
        end

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 600; n++) begin
            int r, q, fe, fa, fl, la;
            r  = int'($urandom_range(0, 149) == 0);
            fl = int'($urandom_range(0, 39) == 0);
            q  = int'($urandom_range(0, 3));
            fe = int'($urandom_range(0, 9) < 4);
            fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            la = int'($urandom_range(0, 19));
            step(r, q, fe, fa, fl, la);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
